// File: rtl/font_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : font_arb_pkg
// Brief    : Shared font ROM constants and the rotating first-set picker.
// Revision : 1.0
// ============================================================================
package font_arb_pkg;

  localparam int FONT_ADDR_W  = 11;
  localparam int FONT_DATA_W  = 16;
  localparam int FONT_ROM_LAT = 1;
  localparam int c_MAX_REQ    = 8;

  // One-hot of the first set bit of req[n-1:0], scanning ptr, ptr+1, ... mod n.
  function automatic logic [c_MAX_REQ-1:0] rr_first_onehot(
    input logic [c_MAX_REQ-1:0] req,
    input logic [2:0]           ptr,
    input int                   n
  );
    logic [c_MAX_REQ-1:0] oh;
    logic                 found;
    int                   idx;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < c_MAX_REQ; k++) begin
      if (k < n && !found) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx[2:0]]) begin
          oh[idx[2:0]] = 1'b1;
          found        = 1'b1;
        end
      end
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/font_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : font_rom_arbiter_if
// Brief    : Requester/ROM bundle of the shared font ROM arbiter.
// Revision : 1.0
// ============================================================================
interface font_rom_arbiter_if
  import font_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = FONT_ADDR_W,
  parameter int DATA_W = FONT_DATA_W
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_data;
  logic [DATA_W-1:0]       rdata;
  logic [N_REQ-1:0]        rvalid;

  modport master (
    output req, addr, rom_data,
    input  gnt, rom_addr, rdata, rvalid
  );

  modport slave (
    input  req, addr, rom_data,
    output gnt, rom_addr, rdata, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin winner select (one-hot and index).
// Revision : 1.0
// ============================================================================
module rr_pick
  import font_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [PTR_W-1:0] win_idx
);

  logic [c_MAX_REQ-1:0] w_oh_full;

  assign w_oh_full = rr_first_onehot(c_MAX_REQ'(req), 3'(ptr), N_REQ);
  assign win_oh    = w_oh_full[N_REQ-1:0];

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < c_MAX_REQ; k++) begin
      if (w_oh_full[k]) win_idx = PTR_W'(k);
    end
  end

endmodule
`default_nettype wire

// File: rtl/font_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : font_rom_arbiter
// Brief    : Round-robin, address-coalescing share of one font ROM.
// Revision : 1.0
// ============================================================================
module font_rom_arbiter
  import font_arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = FONT_ADDR_W,
  parameter int DATA_W  = FONT_DATA_W,
  parameter int ROM_LAT = FONT_ROM_LAT
) (
  input logic               clk,
  input logic               rst,
  font_rom_arbiter_if.slave bus
);

  localparam int c_PTR_W = $clog2(N_REQ);

  logic [c_PTR_W-1:0] r_ptr;
  logic [N_REQ-1:0]   w_win_oh;
  logic [c_PTR_W-1:0] w_win_idx;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [N_REQ-1:0]   w_gnt;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [N_REQ-1:0]   r_tag_pipe [ROM_LAT+1];
  logic [N_REQ-1:0]   r_rvalid;
  logic [DATA_W-1:0]  r_rdata;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req     (bus.req),
    .ptr     (r_ptr),
    .win_oh  (w_win_oh),
    .win_idx (w_win_idx)
  );

  always_comb begin
    w_win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_oh[i]) w_win_addr = bus.addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Every requester waiting on the winner's address rides the same ROM read.
  for (genvar j = 0; j < N_REQ; j++) begin : g_gnt
    assign w_gnt[j] = rst & bus.req[j] & (bus.addr[j*ADDR_W +: ADDR_W] == w_win_addr);
  end

  assign bus.gnt      = w_gnt;
  assign bus.rom_addr = r_rom_addr;
  assign bus.rvalid   = r_rvalid;
  assign bus.rdata    = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= '0;
      r_rom_addr <= '0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
      for (int s = 0; s <= ROM_LAT; s++) r_tag_pipe[s] <= '0;
    end else begin
      if (|w_gnt) begin
        r_ptr      <= (w_win_idx == c_PTR_W'(N_REQ-1)) ? '0 : w_win_idx + c_PTR_W'(1);
        r_rom_addr <= w_win_addr;
      end
      // Stage 0 is the issue tag; stage ROM_LAT lines up with rom_data.
      r_tag_pipe[0] <= w_gnt;
      for (int s = 1; s <= ROM_LAT; s++) r_tag_pipe[s] <= r_tag_pipe[s-1];
      r_rvalid <= r_tag_pipe[ROM_LAT];
      if (|r_tag_pipe[ROM_LAT]) r_rdata <= bus.rom_data;
    end
  end

endmodule
`default_nettype wire
